// File: rtl/random_round_ctrl.sv
// rtl/random_round_ctrl.sv - scrambler round sequencer: permute, random rotate amount, bitwise rotate, valid/ack result (optional RANDOM_NO_REPEAT_EN)
module random_round_ctrl #(
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter int          MAX_DRAW = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] i_num,
    input  logic       i_star,
    input  logic       i_ack,
    output logic [9:0] o_num,
    output logic       o_valid,
    output logic       o_busy,
    output logic [3:0] o_amt
);

    typedef enum logic [1:0] {IDLE, DRAW, ROT, DONE} state_t;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [3:0]  LAST_DRAW = 4'(MAX_DRAW - 1);

    state_t      state, state_n;
    logic [15:0] lfsr;
    logic        star_d;
    logic        rise;
    logic [9:0]  perm;
    logic [9:0]  work, work_n;
    logic [9:0]  o_num_n;
    logic [3:0]  amt, amt_n;
    logic [3:0]  draw_cnt, draw_cnt_n;
    logic [3:0]  prev_amt, prev_amt_n;
    logic [3:0]  o_amt_n;
    logic [3:0]  cand;
    logic [3:0]  fallback;
    logic        reject;
    logic        o_valid_n;

    assign rise   = i_star & ~star_d;
    assign perm   = {i_num[1], i_num[3], i_num[7], i_num[9], i_num[2],
                     i_num[0], i_num[8], i_num[5], i_num[6], i_num[4]};
    assign cand   = lfsr[3:0];
    assign o_busy = (state == DRAW) || (state == ROT);

`ifdef RANDOM_NO_REPEAT_EN
    // Candidate acceptance with repeat exclusion; the fallback steps past prev_amt.
    always_comb begin
        reject   = (cand > 4'd9) || (cand == prev_amt);
        fallback = {1'b0, lfsr[2:0]};
        if (fallback == prev_amt) begin
            fallback = (prev_amt == 4'd9) ? 4'd0 : prev_amt + 4'd1;
        end
    end
`else
    assign reject   = cand > 4'd9;
    assign fallback = {1'b0, lfsr[2:0]};
`endif

    // Free-running Fibonacci LFSR, taps 16,14,13,11; advances in every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_INIT;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and datapath decisions for each phase of a round.
    always_comb begin
        state_n    = state;
        work_n     = work;
        amt_n      = amt;
        draw_cnt_n = draw_cnt;
        prev_amt_n = prev_amt;
        o_num_n    = o_num;
        o_valid_n  = o_valid;
        o_amt_n    = o_amt;
        case (state)
            IDLE: begin
                if (rise) begin
                    work_n     = perm;
                    draw_cnt_n = 4'd0;
                    state_n    = DRAW;
                end
            end
            DRAW: begin
                if (!reject) begin
                    amt_n      = cand;
                    o_amt_n    = cand;
                    prev_amt_n = cand;
                    state_n    = ROT;
                end else if (draw_cnt == LAST_DRAW) begin
                    amt_n      = fallback;
                    o_amt_n    = fallback;
                    prev_amt_n = fallback;
                    state_n    = ROT;
                end else begin
                    draw_cnt_n = draw_cnt + 4'd1;
                end
            end
            ROT: begin
                if (amt != 4'd0) begin
                    work_n = {work[8:0], work[9]};
                    amt_n  = amt - 4'd1;
                end else begin
                    o_num_n   = work;
                    o_valid_n = 1'b1;
                    state_n   = DONE;
                end
            end
            DONE: begin
                if (i_ack) begin
                    o_valid_n = 1'b0;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            star_d   <= 1'b0;
            work     <= 10'd0;
            amt      <= 4'd0;
            draw_cnt <= 4'd0;
            prev_amt <= 4'd0;
            o_num    <= 10'd0;
            o_valid  <= 1'b0;
            o_amt    <= 4'd0;
        end else begin
            star_d   <= i_star;
            work     <= work_n;
            amt      <= amt_n;
            draw_cnt <= draw_cnt_n;
            prev_amt <= prev_amt_n;
            o_num    <= o_num_n;
            o_valid  <= o_valid_n;
            o_amt    <= o_amt_n;
        end
    end

endmodule

// File: tb/tb_random_round_ctrl.sv
// tb/tb_random_round_ctrl.sv - scoreboard bench for random_round_ctrl
module tb_random_round_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] i_num = 10'd0;
    logic       i_star0 = 1'b0, i_star1 = 1'b0;
    logic       i_ack0 = 1'b0, i_ack1 = 1'b0;
    logic [9:0] o_num0, o_num1;
    logic       o_valid0, o_valid1, o_busy0, o_busy1;
    logic [3:0] o_amt0, o_amt1;

    random_round_ctrl u_dut0 (
        .clk(clk), .rst(rst), .i_num(i_num), .i_star(i_star0), .i_ack(i_ack0),
        .o_num(o_num0), .o_valid(o_valid0), .o_busy(o_busy0), .o_amt(o_amt0)
    );

    random_round_ctrl #(.MAX_DRAW(1)) u_dut1 (
        .clk(clk), .rst(rst), .i_num(i_num), .i_star(i_star1), .i_ack(i_ack1),
        .o_num(o_num1), .o_valid(o_valid1), .o_busy(o_busy1), .o_amt(o_amt1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         inst;
        logic [9:0] num;
        logic [3:0] amt;
        int         cyc;
        bit         fb;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         ack_delay = 0;
    int         mon_st = 0, mon_k = 0, wait_cnt = 0;
    int         amt_hits[10];
    int         repeats = 0, fb_cnt = 0;
    bit         have_last = 0;
    logic [3:0] last_amt = 4'd0;
    logic [3:0] model_prev[2];
    logic [15:0] m_lfsr;

    logic [9:0] vec_in[8] = '{10'h001, 10'h3FF, 10'h000, 10'h200, 10'h002, 10'h010, 10'h155, 10'h00F};
    logic [9:0] vec_pm[8] = '{10'h010, 10'h3FF, 10'h000, 10'h040, 10'h200, 10'h001, 10'h03B, 10'h330};

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        logic fb;
        fb = l[15] ^ l[13] ^ l[12] ^ l[10];
        return {l[14:0], fb};
    endfunction

    function automatic logic [9:0] rotl10(input logic [9:0] v, input logic [3:0] r);
        logic [9:0] t;
        t = v;
        for (int i = 0; i < int'(r); i++) t = {t[8:0], t[9]};
        return t;
    endfunction

    // Reference draw: returns accepted amount, number of DRAW cycles, and fallback flag.
    task automatic model_draw(input logic [15:0] l0, input int maxd, input logic [3:0] prev,
                              output logic [3:0] amt, output int d, output bit fb);
        logic [15:0] l;
        logic [3:0]  c, f;
        bit          rej;
        l = l0; d = 0; fb = 0; amt = 4'd0;
        for (int cnt = 0; cnt < 16; cnt++) begin
            d++;
            c = l[3:0];
            rej = (c >= 4'd10);
`ifdef RANDOM_NO_REPEAT_EN
            if (c == prev) rej = 1;
`endif
            if (!rej) begin
                amt = c;
                return;
            end
            if (cnt == maxd - 1) begin
                f = {1'b0, l[2:0]};
`ifdef RANDOM_NO_REPEAT_EN
                if (f == prev) f = (prev == 4'd9) ? 4'd0 : prev + 4'd1;
`endif
                amt = f;
                fb = 1;
                return;
            end
            l = lfsr_step(l);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= lfsr_step(m_lfsr);
    end

    // Monitor: pops the scoreboard on each new result, holds ack off, then checks the drop.
    initial forever begin
        exp_t       e;
        logic       v;
        logic [9:0] n;
        logic [3:0] a;
        @(negedge clk);
        if (rst) begin
            mon_st = 0;
            i_ack0 = 0;
            i_ack1 = 0;
        end else begin
            v = mon_k ? o_valid1 : o_valid0;
            case (mon_st)
                0: if (o_valid0 || o_valid1) begin
                    mon_k = o_valid1 ? 1 : 0;
                    n = mon_k ? o_num1 : o_num0;
                    a = mon_k ? o_amt1 : o_amt0;
                    if (o_valid0 && o_valid1) chk("both_valid", 1, 0);
                    if (q.size() == 0) begin
                        chk("unexpected_valid", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("inst", mon_k, e.inst);
                        chk("o_num", n, e.num);
                        chk("o_amt", a, e.amt);
                        chk("amt_range", a < 4'd10, 1);
                        chk("valid_latency", cyc, e.cyc);
                        if (mon_k == 0) begin
                            if (a < 4'd10) amt_hits[a]++;
                            if (have_last && a == last_amt) repeats++;
`ifdef RANDOM_NO_REPEAT_EN
                            if (have_last) chk("no_repeat", a == last_amt, 0);
`endif
                            have_last = 1;
                            last_amt = a;
                        end else if (e.fb) begin
                            fb_cnt++;
`ifndef RANDOM_NO_REPEAT_EN
                            chk("fallback_lt8", a < 4'd8, 1);
`endif
                        end
                    end
                    if (ack_delay == 0) begin
                        if (mon_k) i_ack1 = 1; else i_ack0 = 1;
                        mon_st = 2;
                    end else begin
                        wait_cnt = ack_delay;
                        mon_st = 1;
                    end
                end
                1: begin
                    chk("valid_hold", v, 1);
                    wait_cnt--;
                    if (wait_cnt == 0) begin
                        if (mon_k) i_ack1 = 1; else i_ack0 = 1;
                        mon_st = 2;
                    end
                end
                default: begin
                    i_ack0 = 0;
                    i_ack1 = 0;
                    chk("valid_drop", v, 0);
                    mon_st = 0;
                end
            endcase
        end
    end

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while ((o_busy0 || o_valid0 || o_busy1 || o_valid1 || mon_st != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) chk("idle_timeout", 0, 1);
    endtask

    // Starts a round on instance k and pushes its expected result.
    task automatic issue(input int k, input logic [9:0] num, input logic [9:0] pm, input bit hold,
                         output int e0, output int d, output logic [3:0] amt);
        exp_t e;
        bit   fb;
        wait_idle();
        i_num = num;
        if (k) i_star1 = 1; else i_star0 = 1;
        @(posedge clk);
        #1;
        e0 = cyc;
        model_draw(m_lfsr, k ? 1 : 8, model_prev[k], amt, d, fb);
        e.inst = k;
        e.num  = rotl10(pm, amt);
        e.amt  = amt;
        e.cyc  = e0 + 1 + d + int'(amt);
        e.fb   = fb;
        q.push_back(e);
        model_prev[k] = amt;
        @(negedge clk);
        i_num = ~num;
        if (!hold) begin
            if (k) i_star1 = 0; else i_star0 = 0;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         e0, d, t;
        logic [3:0] amt;
        bit         hit;
        for (int i = 0; i < 10; i++) amt_hits[i] = 0;
        model_prev[0] = 4'd0;
        model_prev[1] = 4'd0;
        rst = 1;
        repeat (3) @(negedge clk);
        chk("rst_o_num0", o_num0, 0);
        chk("rst_o_valid0", o_valid0, 0);
        chk("rst_o_busy0", o_busy0, 0);
        chk("rst_o_amt0", o_amt0, 0);
        chk("rst_o_num1", o_num1, 0);
        chk("rst_o_valid1", o_valid1, 0);
        chk("rst_o_busy1", o_busy1, 0);
        chk("rst_o_amt1", o_amt1, 0);
        rst = 0;

        // Directed operands with varying ack delays.
        for (int i = 0; i < 8; i++) begin
            ack_delay = i % 4;
            issue(0, vec_in[i], vec_pm[i], 0, e0, d, amt);
        end
        wait_idle();
        ack_delay = 1;

        // i_star held high: exactly one round.
        issue(0, 10'h155, 10'h03B, 1, e0, d, amt);
        repeat (50) @(negedge clk);
        i_star0 = 0;
        wait_idle();

        // Extra rise pulses during DRAW/ROT/DONE and alongside ack.
        issue(0, 10'h2AA, 10'h3C4, 0, e0, d, amt);
        t = 0;
        while ((o_busy0 || o_valid0) && t < 200) begin
            i_star0 = ~i_star0;
            @(negedge clk);
            t++;
        end
        i_star0 = 0;
        repeat (40) @(negedge clk);
        wait_idle();
        ack_delay = 0;

        // Async reset in the middle of ROT.
        hit = 0;
        for (int r = 0; r < 40 && !hit; r++) begin
            issue(0, vec_in[r % 8], vec_pm[r % 8], 0, e0, d, amt);
            if (amt >= 4'd2) begin
                while (cyc < e0 + d + 2) @(negedge clk);
                rst = 1;
                #1;
                chk("midrot_o_valid", o_valid0, 0);
                chk("midrot_o_busy", o_busy0, 0);
                chk("midrot_o_num", o_num0, 0);
                chk("midrot_o_amt", o_amt0, 0);
                q.delete();
                model_prev[0] = 4'd0;
                model_prev[1] = 4'd0;
                have_last = 0;
                hit = 1;
                @(negedge clk);
                rst = 0;
            end
        end
        chk("midrot_reached", hit, 1);
        issue(0, 10'h001, 10'h010, 0, e0, d, amt);

        // Long run of back-to-back rounds.
        for (int r = 0; r < 1000; r++) begin
            issue(0, vec_in[r % 8], vec_pm[r % 8], 0, e0, d, amt);
        end
        wait_idle();
        for (int i = 0; i < 10; i++) chk($sformatf("amt_hit_%0d", i), amt_hits[i] > 0, 1);
`ifndef RANDOM_NO_REPEAT_EN
        chk("repeat_seen", repeats > 0, 1);
`endif

        // MAX_DRAW=1 instance: fallback path.
        for (int r = 0; r < 200; r++) begin
            issue(1, vec_in[r % 8], vec_pm[r % 8], 0, e0, d, amt);
        end
        wait_idle();
        chk("fallback_seen", fb_cnt > 0, 1);
        repeat (20) @(negedge clk);
        chk("queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/random_round_ctrl.md
Name: random_round_ctrl

Overview:
- Sequencing controller for the 10-bit number scrambler in the game datapath.
- On a start request (i_star), it latches and permutes the operand, then draws a pseudo-random rotate amount 0..9 from an internal LFSR.
- It applies the rotation one bit per cycle and presents the result with a valid/ack handshake.
- Fully synthesizable: no simulation-only random calls.

Parameters:
- SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'h0001.
- MAX_DRAW, 8, rejected draws allowed before the fallback amount is forced (range 1..15).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- i_num  input  10  operand, sampled on start
- i_star  input  1  start request, level; a 0->1 transition (sampled on clk) starts a round
- i_ack  input  1  consumer accepts the result
- o_num  output  10  scrambled and rotated result
- o_valid  output  1  result valid, held until i_ack
- o_busy  output  1  high in DRAW and ROT
- o_amt  output  4  rotate amount accepted for the current/last round

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; o_num, o_valid, o_busy, o_amt, prev_amt, star_d, draw_cnt all 0.
  - lfsr=SEED (or 1 if SEED==0).
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle in every state; never all-zero.
- Start edge detection:
  - star_d <= i_star every cycle.
  - rise = i_star & ~star_d.
  - rise outside IDLE is ignored and not queued. A held-high i_star never retriggers.
- Permutation (MSB..LSB): {i1,i3,i7,i9,i2,i0,i8,i5,i6,i4}.
- States:
  - IDLE:
    - o_busy=0.
    - On rise: work <= permuted i_num, draw_cnt <= 0, go DRAW.
    - o_num keeps the last result.
  - DRAW:
    - cand = lfsr[3:0]. If cand<10, accept: amt<=cand, o_amt<=cand, prev_amt<=cand, go ROT.
    - Otherwise draw_cnt++.
    - If draw_cnt==MAX_DRAW-1 and the candidate is rejected, accept the fallback lfsr[2:0] instead (always <10).
  - ROT:
    - If amt!=0: work <= {work[8:0],work[9]} (rotate left 1), amt--.
    - If amt==0: o_num<=work, o_valid<=1, go DONE.
  - DONE:
    - o_valid=1, o_busy=0.
    - On i_ack: o_valid<=0, go IDLE.
    - A rise in the same cycle as i_ack is ignored.
- Latency:
  - Rise sampled at edge E0 puts the block in DRAW.
  - Accept at E1 at the earliest.
  - o_valid rises after E(2+amt+rejections). For amt=0 and no rejection, o_valid rises after E2.
- Result definition: o_num == rotl10(permute(i_num at start), o_amt).
- i_num changes after E0 do not affect the round.
- Async reset mid-round: immediate return to the reset state; the partial result is discarded; o_valid drops without ack.

Optional Feature:
- Macro: RANDOM_NO_REPEAT_EN.
- Defined:
  - In DRAW, a candidate equal to prev_amt is also rejected, so consecutive rounds never share a rotate amount.
  - The fallback becomes (prev_amt+1) mod 10 when lfsr[2:0]==prev_amt.
  - The first round after reset treats prev_amt=0 as a valid exclusion.
- Undefined: repeats allowed; prev_amt is not used in the accept decision.

Test Plan:
- Reset with SEED default -> all outputs 0, state IDLE, o_busy=0; apply rst mid-ROT -> o_valid/o_busy=0 the same cycle, and the next round behaves normally.
- i_num=10'h001, rise on i_star -> o_amt<=9, o_num==rotl10(10'h010,o_amt), o_valid asserted o_amt+2+rejections cycles after the rise edge, held until i_ack pulse, deasserted the cycle after ack.
- i_num=10'h3FF and i_num=10'h000 -> o_num 10'h3FF and 10'h000 respectively, for any o_amt.
- i_star held high 50 cycles, plus extra rise pulses during DRAW/ROT/DONE and with i_ack -> exactly one round; no second o_valid without a fresh rise from IDLE.
- 1000 rounds with a scoreboard LFSR model -> every o_amt in 0..9, each value hit at least once, o_num matches the model every round; MAX_DRAW=1 -> fallback path exercised with o_amt<8.
- With RANDOM_NO_REPEAT_EN, 1000 back-to-back rounds -> o_amt never equals the previous round's o_amt; without it, at least one repeat observed.
